// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and the keyboard receiver:
//   ps2_state_t  - host transmitter FSM states
//   ps2_status_t - completion status reported with tx_done
//   PS2_*        - default timing constants for a ~13 MHz clk_sys
//   ps2_frame()  - builds the 10-bit shift frame {stop, odd parity, data}
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  typedef enum logic [1:0] {
    PS2_OK      = 2'b00,
    PS2_NOACK   = 2'b01,
    PS2_TIMEOUT = 2'b10
  } ps2_status_t;

  localparam int unsigned PS2_INHIBIT_CYCLES = 1560;    // 120 us @ 13 MHz
  localparam int unsigned PS2_REQ_CYCLES     = 16;
  localparam int unsigned PS2_REQ_TIMEOUT    = 195000;  // 15 ms
  localparam int unsigned PS2_BIT_TIMEOUT    = 26000;   // 2 ms
  localparam int unsigned PS2_FILTER_LEN     = 4;
  localparam int unsigned PS2_CNT_W          = 18;

  // Stop bit in [9] so that shifting right fills with released (1) bits.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Byte request/completion handshake between a command source and ps2_host_tx.
//   tx_data   - byte to send (sampled only on accept)
//   tx_valid  - request; accepted when tx_valid & tx_ready
//   tx_ready  - transmitter idle
//   tx_done   - one-cycle completion pulse
//   tx_status - 00 ok, 01 no-ack, 10 timeout; valid with tx_done
// Modports: master = command source, slave = transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic [1:0] tx_status;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_status
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_status
  );

endinterface

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Conditions the raw PS/2 pad levels for use in the clk domain.
//   clk, reset  - system clock, synchronous active-high reset
//   clk_in      - raw ps2 clock pad level (asynchronous)
//   data_in     - raw ps2 data pad level (asynchronous)
//   clk_filt    - synchronised clock level, changes only after FILTER_LEN
//                 consecutive samples of the new level
//   data_sync   - 2-FF synchronised data level
//   clk_fall    - one-cycle strobe on a filtered 1->0 clock transition
// ---------------------------------------------------------------------------
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_filt,
  output logic data_sync,
  output logic clk_fall
);

  localparam int unsigned FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic [FW-1:0] flt_cnt;

  assign data_sync = data_meta[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= '1;
      data_meta <= '1;
      clk_filt  <= 1'b1;
      flt_cnt   <= '0;
      clk_fall  <= 1'b0;
    end else begin
      clk_meta  <= {clk_meta[0], clk_in};
      data_meta <= {data_meta[0], data_in};
      clk_fall  <= 1'b0;
      // flt_cnt counts samples that disagree with the accepted level; any
      // agreeing sample restarts the run, so short glitches are dropped.
      if (clk_meta[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_meta[1];
        flt_cnt  <= '0;
        clk_fall <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// over open-drain clock/data lines shared with the keyboard receiver.
//   clk_sys      - system clock (~13 MHz)
//   reset        - synchronous, active-high
//   tx           - byte handshake (ps2_host_tx_if.slave)
//   rx_inhibit   - high while a host transfer owns the lines (not IDLE)
//   ps2_clk_in   - raw clock pad level
//   ps2_data_in  - raw data pad level
//   ps2_clk_oe   - 1 = pull clock low
//   ps2_data_oe  - 1 = pull data low
// Sequence: INHIBIT (clock low) -> REQ (clock+data low) -> SEND (device
// clocks 10 bits out) -> ACK (11th edge samples ack) -> WAIT_IDLE.
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned REQ_CYCLES     = PS2_REQ_CYCLES,
  parameter int unsigned REQ_TIMEOUT    = PS2_REQ_TIMEOUT,
  parameter int unsigned BIT_TIMEOUT    = PS2_BIT_TIMEOUT,
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic               clk_sys,
  input  logic               reset,
  ps2_host_tx_if.slave       tx,
  output logic               rx_inhibit,
  input  logic               ps2_clk_in,
  input  logic               ps2_data_in,
  output logic               ps2_clk_oe,
  output logic               ps2_data_oe
);

  ps2_state_t           state;
  ps2_state_t           state_nx;
  logic [PS2_CNT_W-1:0] cnt;
  logic [PS2_CNT_W-1:0] tmo_limit;
  logic [9:0]           shreg;
  logic [3:0]           bit_cnt;
  logic                 data_drive;
  logic                 first_seen;
  logic                 nack;
  logic                 clk_filt;
  logic                 data_sync;
  logic                 clk_fall;
  logic                 accept;
  logic                 in_xfer;
  logic                 line_idle;
  logic                 tmo_expired;

  ps2_line_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_sync (
    .clk       (clk_sys),
    .reset     (reset),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_filt  (clk_filt),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign accept    = tx.tx_valid && (state == IDLE);
  assign in_xfer   = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign line_idle = clk_filt && data_sync;
  assign tmo_limit = first_seen ? PS2_CNT_W'(BIT_TIMEOUT) : PS2_CNT_W'(REQ_TIMEOUT);
  assign tmo_expired = in_xfer && (cnt >= tmo_limit);

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = INHIBIT;
      end
      INHIBIT: begin
        if (cnt == PS2_CNT_W'(INHIBIT_CYCLES - 1)) state_nx = REQ;
      end
      REQ: begin
        if (cnt == PS2_CNT_W'(REQ_CYCLES - 1)) state_nx = SEND;
      end
      SEND: begin
        if (tmo_expired) state_nx = IDLE;
        else if (clk_fall && (bit_cnt == 4'd9)) state_nx = ACK;
      end
      ACK: begin
        if (tmo_expired) state_nx = IDLE;
        else if (clk_fall) state_nx = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (line_idle || tmo_expired) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One counter times INHIBIT/REQ and the transfer timeouts: it restarts on
  // every state change and on every device falling edge, and saturates.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == IDLE) || (state != state_nx)) begin
      cnt <= '0;
    end else if (clk_fall && ((state == SEND) || (state == ACK))) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + PS2_CNT_W'(1);
    end
  end

  // Frame datapath
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shreg      <= '1;
      bit_cnt    <= '0;
      data_drive <= 1'b0;
      first_seen <= 1'b0;
      nack       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          data_drive <= 1'b0;
          if (accept) begin
            shreg      <= ps2_frame(tx.tx_data);
            bit_cnt    <= '0;
            first_seen <= 1'b0;
            nack       <= 1'b0;
          end
        end
        // The start bit stays driven into SEND until the first device edge.
        REQ: data_drive <= 1'b1;
        SEND: begin
          if (clk_fall) begin
            data_drive <= ~shreg[0];
            shreg      <= {1'b1, shreg[9:1]};
            bit_cnt    <= bit_cnt + 4'd1;
            first_seen <= 1'b1;
          end
        end
        ACK: begin
          if (clk_fall) nack <= data_sync;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    tx.tx_ready  = (state == IDLE);
    rx_inhibit   = (state != IDLE);
    ps2_clk_oe   = (state == INHIBIT) || (state == REQ);
    ps2_data_oe  = (state == REQ) || ((state == SEND) && data_drive);
    tx.tx_done   = 1'b0;
    tx.tx_status = PS2_OK;
    if (!reset) begin
      if ((state == WAIT_IDLE) && line_idle) begin
        tx.tx_done   = 1'b1;
        tx.tx_status = nack ? PS2_NOACK : PS2_OK;
      end else if (tmo_expired) begin
        tx.tx_done   = 1'b1;
        tx.tx_status = PS2_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  // Shortened timing so each scenario completes in a few thousand cycles.
  localparam int unsigned INH     = 200;
  localparam int unsigned REQC    = 16;
  localparam int unsigned REQ_TMO = 3000;
  localparam int unsigned BIT_TMO = 700;
  localparam int unsigned HALF    = 40;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic rx_inhibit;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_in;
  logic ps2_data_in;

  // Open-drain wired-AND of device and host.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQC),
    .REQ_TIMEOUT    (REQ_TMO),
    .BIT_TIMEOUT    (BIT_TMO),
    .FILTER_LEN     (4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .tx          (tx_if),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         done_count = 0;
  int         done_cyc = 0;
  logic [1:0] last_status = 2'b00;
  bit         post_pending = 0;
  logic       post_ready = 1'b0;
  logic       post_clk_oe = 1'b1;
  logic       post_data_oe = 1'b1;

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (post_pending) begin
      post_ready   = tx_if.tx_ready;
      post_clk_oe  = ps2_clk_oe;
      post_data_oe = ps2_data_oe;
      post_pending = 0;
    end
    if (tx_if.tx_done === 1'b1) begin
      done_count   = done_count + 1;
      done_cyc     = cyc;
      last_status  = tx_if.tx_status;
      post_pending = 1;
    end
  end

  // Accepts one byte and measures the inhibit (clock low only) and request
  // (clock and data low) phases; returns at the first cycle with clock released.
  task automatic start_send(input logic [7:0] b, output int inh_n, output int req_n,
                            output int rel_cyc);
    @(negedge clk_sys);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    #1;
    checks++;
    if (tx_if.tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: got %b expected 1", tx_if.tx_ready);
    end
    @(negedge clk_sys);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h5A;
    #1;
    inh_n = 0;
    req_n = 0;
    for (int i = 0; i < int'(INH + REQC + 50); i++) begin
      if (ps2_clk_oe && !ps2_data_oe) inh_n++;
      else if (ps2_clk_oe && ps2_data_oe) req_n++;
      else break;
      @(negedge clk_sys);
      #1;
    end
    rel_cyc = cyc;
  endtask

  // Device clocking model: frame[0] is the level before the first falling
  // edge (start), frame[k] the level at rising edge k (k = 1..10).
  task automatic device_frame(input int n_pulses, input bit do_ack, input int glitch_at,
                              output logic [10:0] frame);
    frame = '0;
    repeat (20) @(negedge clk_sys);
    frame[0] = ps2_data_in;
    for (int k = 1; k <= n_pulses; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      dev_clk = 1'b1;
      if (k <= 10) frame[k] = ps2_data_in;
      if (k == glitch_at) begin
        repeat (HALF / 2) @(negedge clk_sys);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk_sys);
        dev_clk = 1'b1;
        repeat (HALF / 2 - 2) @(negedge clk_sys);
      end else if ((k == 10) && do_ack) begin
        repeat (HALF / 2) @(negedge clk_sys);
        dev_data = 1'b0;
        repeat (HALF / 2) @(negedge clk_sys);
      end else begin
        repeat (HALF) @(negedge clk_sys);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int base, input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_count > base) begin
        seen = 1;
        break;
      end
      @(negedge clk_sys);
      #1;
    end
    if (seen) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  // Full frame with ack; checks bit sequence, status 00 and ready afterwards.
  task automatic full_send(input string name, input logic [7:0] b, input logic par,
                           input int glitch_at);
    int inh_n, req_n, rel_c, base;
    logic [10:0] fr;
    logic [10:0] exp_fr;
    bit seen;
    base = done_count;
    start_send(b, inh_n, req_n, rel_c);
    device_frame(11, 1'b1, glitch_at, fr);
    wait_done(base, 200, seen);
    exp_fr = {1'b1, par, b, 1'b0};
    checks++;
    if (fr !== exp_fr) begin
      failures++;
      $display("FAIL %s_frame: got %b expected %b", name, fr, exp_fr);
    end
    checks++;
    if (!seen || (last_status !== 2'b00) || (done_count != base + 1)) begin
      failures++;
      $display("FAIL %s_done: seen=%0b status=%b dones=%0d expected 1 status 00 dones=%0d",
               name, seen, last_status, done_count, base + 1);
    end
    checks++;
    if ((post_ready !== 1'b1) || (post_clk_oe !== 1'b0) || (post_data_oe !== 1'b0)) begin
      failures++;
      $display("FAIL %s_after: ready=%b clk_oe=%b data_oe=%b expected 1 0 0",
               name, post_ready, post_clk_oe, post_data_oe);
    end
  endtask

  task automatic test_reset;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    #1;
    checks++;
    if ({tx_if.tx_ready, tx_if.tx_done, tx_if.tx_status, rx_inhibit, ps2_clk_oe, ps2_data_oe}
        !== 7'b1_0_00_0_0_0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 1000000",
               {tx_if.tx_ready, tx_if.tx_done, tx_if.tx_status, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    checks++;
    if ((tx_if.tx_ready !== 1'b1) || (rx_inhibit !== 1'b0)) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%b inhibit=%b expected 1 0", tx_if.tx_ready, rx_inhibit);
    end
  endtask

  task automatic test_send_ed;
    int inh_n, req_n, rel_c, base;
    logic [10:0] fr;
    bit seen;
    base = done_count;
    start_send(8'hED, inh_n, req_n, rel_c);
    checks++;
    if (inh_n != int'(INH)) begin
      failures++;
      $display("FAIL inhibit_len: got %0d expected %0d", inh_n, INH);
    end
    checks++;
    if (req_n != int'(REQC)) begin
      failures++;
      $display("FAIL req_len: got %0d expected %0d", req_n, REQC);
    end
    checks++;
    if (rx_inhibit !== 1'b1) begin
      failures++;
      $display("FAIL rx_inhibit_busy: got %b expected 1", rx_inhibit);
    end
    device_frame(11, 1'b1, 0, fr);
    wait_done(base, 200, seen);
    checks++;
    if (fr !== 11'b1_1_11101101_0) begin
      failures++;
      $display("FAIL ed_frame: got %b expected 11111011010", fr);
    end
    checks++;
    if (!seen || (last_status !== 2'b00)) begin
      failures++;
      $display("FAIL ed_done: seen=%0b status=%b expected 1 00", seen, last_status);
    end
    checks++;
    if ((post_ready !== 1'b1) || (rx_inhibit !== 1'b0)) begin
      failures++;
      $display("FAIL ed_idle: ready=%b inhibit=%b expected 1 0", post_ready, rx_inhibit);
    end
  endtask

  task automatic test_parity;
    full_send("x01", 8'h01, 1'b0, 0);
    full_send("xff", 8'hFF, 1'b1, 0);
  endtask

  task automatic test_req_timeout;
    int inh_n, req_n, rel_c, base;
    bit seen;
    base = done_count;
    start_send(8'hA5, inh_n, req_n, rel_c);
    wait_done(base, int'(REQ_TMO) + 100, seen);
    checks++;
    if (!seen || (last_status !== 2'b10)) begin
      failures++;
      $display("FAIL req_tmo_status: seen=%0b status=%b expected 1 10", seen, last_status);
    end
    checks++;
    if ((done_cyc - rel_c) != int'(REQ_TMO)) begin
      failures++;
      $display("FAIL req_tmo_time: got %0d expected %0d", done_cyc - rel_c, REQ_TMO);
    end
    checks++;
    if ((post_ready !== 1'b1) || (post_clk_oe !== 1'b0) || (post_data_oe !== 1'b0)) begin
      failures++;
      $display("FAIL req_tmo_release: ready=%b clk_oe=%b data_oe=%b expected 1 0 0",
               post_ready, post_clk_oe, post_data_oe);
    end
  endtask

  // Device stops after 5 clocks. Its last falling edge is 2*HALF before the
  // model returns; the host sees it ~7 cycles later and times out BIT_TMO+1
  // cycles after that, i.e. about BIT_TMO - 2*HALF + 8 after the return.
  task automatic test_bit_timeout;
    int inh_n, req_n, rel_c, base, end_c, dt;
    logic [10:0] fr;
    bit seen;
    base = done_count;
    start_send(8'hED, inh_n, req_n, rel_c);
    device_frame(5, 1'b0, 0, fr);
    #1;
    end_c = cyc;
    wait_done(base, int'(BIT_TMO) + 100, seen);
    dt = done_cyc - end_c;
    checks++;
    if (!seen || (last_status !== 2'b10)) begin
      failures++;
      $display("FAIL bit_tmo_status: seen=%0b status=%b expected 1 10", seen, last_status);
    end
    checks++;
    if ((dt < int'(BIT_TMO - 2 * HALF)) || (dt > int'(BIT_TMO - 2 * HALF + 15))) begin
      failures++;
      $display("FAIL bit_tmo_time: got %0d expected %0d..%0d", dt, BIT_TMO - 2 * HALF,
               BIT_TMO - 2 * HALF + 15);
    end
    checks++;
    if ((post_clk_oe !== 1'b0) || (post_data_oe !== 1'b0) || (post_ready !== 1'b1)) begin
      failures++;
      $display("FAIL bit_tmo_release: clk_oe=%b data_oe=%b ready=%b expected 0 0 1",
               post_clk_oe, post_data_oe, post_ready);
    end
  endtask

  task automatic test_back_to_back;
    int inh_n, req_n, rel_c, base;
    logic [10:0] fr;
    bit seen;
    base = done_count;
    start_send(8'h55, inh_n, req_n, rel_c);
    device_frame(11, 1'b0, 0, fr);
    wait_done(base, 200, seen);
    checks++;
    if (fr !== 11'b1_1_01010101_0) begin
      failures++;
      $display("FAIL noack_frame: got %b expected 11010101010", fr);
    end
    checks++;
    if (!seen || (last_status !== 2'b01)) begin
      failures++;
      $display("FAIL noack_status: seen=%0b status=%b expected 1 01", seen, last_status);
    end
    full_send("xf4", 8'hF4, 1'b0, 0);
  endtask

  task automatic test_reset_mid_send;
    int inh_n, req_n, rel_c, base;
    logic [10:0] fr;
    base = done_count;
    start_send(8'hED, inh_n, req_n, rel_c);
    device_frame(5, 1'b0, 0, fr);
    #1;
    // After the 5th edge bit 4 of 0xED (a 0) is on the line.
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      failures++;
      $display("FAIL bit4_driven: got %b expected 1", ps2_data_oe);
    end
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    #1;
    checks++;
    if ((ps2_clk_oe !== 1'b0) || (ps2_data_oe !== 1'b0) || (tx_if.tx_ready !== 1'b1)) begin
      failures++;
      $display("FAIL reset_release: clk_oe=%b data_oe=%b ready=%b expected 0 0 1",
               ps2_clk_oe, ps2_data_oe, tx_if.tx_ready);
    end
    repeat (50) @(negedge clk_sys);
    #1;
    checks++;
    if (done_count != base) begin
      failures++;
      $display("FAIL reset_no_done: got %0d dones expected %0d", done_count, base);
    end
    // Re-issue with a 2-cycle clock glitch in the high phase after edge 3.
    full_send("reissue_glitch", 8'hED, 1'b1, 3);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_req_timeout();
    test_bit_timeout();
    test_back_to_back();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
